// File: rtl/ex_stage.sv
// Execute stage: ALU, optional iterative multiply/divide with HI/LO, and the EX/MEM register.
// Define MULDIV_EN to build the multiply/divide unit; otherwise mult/div issue as bubbles.
`timescale 1ns/1ps
module ex_stage (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [185:0] id_ex,
    output logic [116:0] ex_mem,
    output logic         stall_req,
    output logic [31:0]  hi,
    output logic [31:0]  lo,
    output logic         md_busy
);
    logic [4:0]  rt, rd, shamt, dest;
    logic [31:0] rt_data, imm, rs_data, pc1_stored;
    logic [15:0] controls;
    logic [3:0]  alu_op;
    logic        alu_src, reg_dst, mfhi, mflo, is_md, is_bubble;
    logic [31:0] op_a, op_b, alu_res, result;

    assign rt         = id_ex[185:181];
    assign rd         = id_ex[180:176];
    assign rt_data    = id_ex[175:144];
    assign imm        = id_ex[143:112];
    assign rs_data    = id_ex[111:80];
    assign pc1_stored = id_ex[47:16];
    assign controls   = id_ex[15:0];

    assign alu_op  = controls[3:0];
    assign alu_src = controls[4];
    assign reg_dst = controls[5];
    assign mfhi    = controls[9];
    assign mflo    = controls[10];
    assign shamt   = imm[10:6];
    assign is_md   = alu_op[3] & alu_op[2];

    assign op_a = rs_data;
    assign op_b = alu_src ? imm : rt_data;
    assign dest = reg_dst ? rd : rt;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0:    alu_res = op_a + op_b;
            4'd1:    alu_res = op_a - op_b;
            4'd2:    alu_res = op_a & op_b;
            4'd3:    alu_res = op_a | op_b;
            4'd4:    alu_res = op_a ^ op_b;
            4'd5:    alu_res = ~(op_a | op_b);
            4'd6:    alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
            4'd7:    alu_res = {31'b0, op_a < op_b};
            4'd8:    alu_res = op_b << shamt;
            4'd9:    alu_res = op_b >> shamt;
            4'd10:   alu_res = $signed(op_b) >>> shamt;
            4'd11:   alu_res = {imm[15:0], 16'b0};
            default: alu_res = '0;
        endcase
    end

    // mfhi takes precedence if a malformed bundle sets both read flags
    assign result = mfhi ? hi : (mflo ? lo : alu_res);

    // Flushes, mult/div issue and stalled cycles all leave EX as an all-zero bundle
    assign is_bubble = (controls == 16'd0) | is_md | stall_req;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_mem <= '0;
        end else if (is_bubble) begin
            ex_mem <= '0;
        end else begin
            ex_mem <= {dest, result, rt_data, pc1_stored, controls};
        end
    end

`ifdef MULDIV_EN
    logic [31:0] acc_reg, acc_next, q_reg, q_next, d_reg, hi_reg, lo_reg;
    logic [5:0]  cnt_reg;
    logic        busy_reg, div_reg, negq_reg, negr_reg, div0_reg;
    logic        md_start, md_last, sgn_op, sa, sb;
    logic [31:0] abs_a, abs_b, quo_fix, rem_fix;
    logic [32:0] sum, shifted;
    logic [33:0] trial;
    logic [63:0] prod, prod_fix;
    wire         unused_bits = ^{id_ex[79:48], trial[32]};

    assign md_start = is_md & ~busy_reg;
    assign sgn_op   = ~alu_op[0];
    assign sa       = sgn_op & op_a[31];
    assign sb       = sgn_op & op_b[31];
    assign abs_a    = sa ? -op_a : op_a;
    assign abs_b    = sb ? -op_b : op_b;

    // One iteration: q holds multiplier/dividend bits, acc the partial product/remainder
    always_comb begin
        acc_next = acc_reg;
        q_next   = q_reg;
        sum      = '0;
        shifted  = '0;
        trial    = '0;
        if (div_reg) begin
            shifted = {acc_reg, q_reg[31]};
            trial   = {1'b0, shifted} - {2'b0, d_reg};
            if (!trial[33]) begin
                acc_next = trial[31:0];
                q_next   = {q_reg[30:0], 1'b1};
            end else begin
                acc_next = shifted[31:0];
                q_next   = {q_reg[30:0], 1'b0};
            end
        end else begin
            sum      = {1'b0, acc_reg} + {1'b0, (q_reg[0] ? d_reg : 32'd0)};
            acc_next = sum[32:1];
            q_next   = {sum[0], q_reg[31:1]};
        end
    end

    assign prod     = {acc_next, q_next};
    assign prod_fix = negq_reg ? -prod : prod;
    assign quo_fix  = div0_reg ? 32'hFFFF_FFFF : (negq_reg ? -q_next : q_next);
    assign rem_fix  = negr_reg ? -acc_next : acc_next;
    assign md_last  = busy_reg && (cnt_reg == 6'd31);

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg  <= '0;
            q_reg    <= '0;
            d_reg    <= '0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            div_reg  <= 1'b0;
            negq_reg <= 1'b0;
            negr_reg <= 1'b0;
            div0_reg <= 1'b0;
        end else if (md_start) begin
            busy_reg <= 1'b1;
            cnt_reg  <= '0;
            div_reg  <= alu_op[1];
            negq_reg <= sa ^ sb;
            negr_reg <= sa;
            div0_reg <= (op_b == 32'd0);
            acc_reg  <= '0;
            q_reg    <= abs_a;
            d_reg    <= abs_b;
        end else if (busy_reg) begin
            acc_reg <= acc_next;
            q_reg   <= q_next;
            cnt_reg <= cnt_reg + 6'd1;
            if (md_last) begin
                busy_reg <= 1'b0;
                cnt_reg  <= '0;
                if (div_reg) begin
                    hi_reg <= rem_fix;
                    lo_reg <= quo_fix;
                end else begin
                    hi_reg <= prod_fix[63:32];
                    lo_reg <= prod_fix[31:0];
                end
            end
        end
    end

    assign hi        = hi_reg;
    assign lo        = lo_reg;
    assign md_busy   = busy_reg;
    assign stall_req = busy_reg & (is_md | mfhi | mflo);
`else
    wire unused_bits = ^id_ex[79:48];

    assign hi        = '0;
    assign lo        = '0;
    assign md_busy   = 1'b0;
    assign stall_req = 1'b0;
`endif
endmodule

// File: tb/tb_ex_stage.sv
// Randomized bench for ex_stage; expectations come from a plain-arithmetic model of the execute rules.
`timescale 1ns/1ps
module tb_ex_stage;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [185:0] id_ex = '0;
    logic [116:0] ex_mem;
    logic         stall_req;
    logic [31:0]  hi, lo;
    logic         md_busy;

    int checks = 0;
    int passed = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

`ifdef MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_ex(id_ex), .ex_mem(ex_mem),
        .stall_req(stall_req), .hi(hi), .lo(lo), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [185:0] mk(input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [31:0] rtd, input logic [31:0] imm,
                                        input logic [31:0] rs, input logic [15:0] ctl);
        logic [31:0] pc, pc1;
        pc  = $urandom();
        pc1 = $urandom();
        return {rt, rd, rtd, imm, rs, pc, pc1, ctl};
    endfunction

    // Expected EX/MEM contents for a non-stalled bundle
    function automatic logic [116:0] model_ex(input logic [185:0] b, input logic [31:0] h,
                                              input logic [31:0] l);
        logic [15:0] c;
        logic [31:0] a, bb, im, r;
        int sh;
        c  = b[15:0];
        im = b[143:112];
        a  = b[111:80];
        bb = c[4] ? im : b[175:144];
        sh = int'(im[10:6]);
        if (c == 16'd0 || c[3:0] >= 4'd12) return '0;
        case (c[3:0])
            4'd0:  r = a + bb;
            4'd1:  r = a - bb;
            4'd2:  r = a & bb;
            4'd3:  r = a | bb;
            4'd4:  r = a ^ bb;
            4'd5:  r = ~(a | bb);
            4'd6:  r = ($signed(a) < $signed(bb)) ? 32'd1 : 32'd0;
            4'd7:  r = (a < bb) ? 32'd1 : 32'd0;
            4'd8:  r = bb << sh;
            4'd9:  r = bb >> sh;
            4'd10: r = 32'(longint'($signed(bb)) >>> sh);
            default: r = 32'(longint'(im[15:0]) * 65536);
        endcase
        if (c[9]) r = h;
        else if (c[10]) r = l;
        return {(c[5] ? b[180:176] : b[185:181]), r, b[175:144], b[47:16], c};
    endfunction

    task automatic model_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        if (!MD) return;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd12: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd13: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
            4'd14: if (b == 0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
                   else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
            default: if (b == 0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
                     else begin m_lo = a / b; m_hi = a % b; end
        endcase
    endtask

    function automatic logic [15:0] rand_ctl(input bit allow_hilo);
        logic [15:0] c;
        int sel;
        c = 16'($urandom());
        c[3:0] = 4'($urandom_range(0, 11));
        c[10:9] = 2'b00;
        if (allow_hilo) begin
            sel = $urandom_range(0, 5);
            if (sel == 0) c[9] = 1'b1;
            else if (sel == 1) c[10] = 1'b1;
        end
        if ($urandom_range(0, 9) == 0) c = 16'h0;
        return c;
    endfunction

    function automatic logic [185:0] rand_bundle(input bit allow_hilo);
        return mk(5'($urandom()), 5'($urandom()), $urandom(), $urandom(), $urandom(),
                  rand_ctl(allow_hilo));
    endfunction

    task automatic step(input logic [185:0] b);
        @(posedge clk);
        #1 id_ex = b;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (md_busy && cyc < 50) begin
            @(negedge clk);
            #1 cyc++;
        end
    endtask

    task automatic test_reset();
        logic [185:0] b;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({ex_mem, hi, lo, md_busy, stall_req} !== '0)
            $display("FAIL reset_initial: got ex_mem=%h hi=%h lo=%h busy=%b stall=%b expected all zero",
                     ex_mem, hi, lo, md_busy, stall_req); else passed++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        b = mk(5'd2, 5'd9, 32'd10, 32'd0, 32'd20, 16'h0060);
        step(b);
        checks++; if (ex_mem !== model_ex(b, m_hi, m_lo))
            $display("FAIL reset_pre_add: got %h expected %h", ex_mem, model_ex(b, m_hi, m_lo)); else passed++;
        @(posedge clk);
        #2 rst_n = 1'b0;
        id_ex = '0;
        #1;
        checks++; if ({ex_mem, hi, lo, md_busy} !== '0)
            $display("FAIL reset_async: got ex_mem=%h hi=%h lo=%h busy=%b expected all zero",
                     ex_mem, hi, lo, md_busy); else passed++;
        #1 rst_n = 1'b1;
        $display("reset: async clear checked");
    endtask

    task automatic test_alu_directed();
        logic [185:0] b;
        b = mk(5'd1, 5'd5, 32'd1, 32'd0, 32'hFFFF_FFFF, 16'h0060);
        step(b);
        checks++; if ({ex_mem[116:112], ex_mem[111:80], ex_mem[6]} !== {5'd5, 32'd0, 1'b1})
            $display("FAIL add_wrap: got dest=%0d result=%h rw=%b expected dest=5 result=0 rw=1",
                     ex_mem[116:112], ex_mem[111:80], ex_mem[6]); else passed++;
        b = mk(5'd1, 5'd5, 32'd1, 32'd0, 32'hFFFF_FFFE, 16'h0046);
        step(b);
        checks++; if (ex_mem[111:80] !== 32'd1)
            $display("FAIL slt: got %h expected 1", ex_mem[111:80]); else passed++;
        b = mk(5'd1, 5'd5, 32'd1, 32'd0, 32'hFFFF_FFFE, 16'h0047);
        step(b);
        checks++; if (ex_mem[111:80] !== 32'd0)
            $display("FAIL sltu: got %h expected 0", ex_mem[111:80]); else passed++;
        b = mk(5'd1, 5'd5, 32'h8000_0000, 32'h0000_0100, 32'd0, 16'h004A);
        step(b);
        checks++; if (ex_mem[111:80] !== 32'hF800_0000)
            $display("FAIL sra: got %h expected f8000000", ex_mem[111:80]); else passed++;
        $display("alu_directed: add/slt/sltu/sra done");
    endtask

    task automatic test_alu_random();
        logic [185:0] b;
        logic [116:0] e;
        for (int i = 0; i < 40; i++) begin
            b = rand_bundle(1'b1);
            step(b);
            e = model_ex(b, m_hi, m_lo);
            checks++; if (ex_mem !== e)
                $display("FAIL alu_rand_%0d: op=%0d got %h expected %h", i, b[3:0], ex_mem, e);
            else passed++;
            $display("alu_rand %0d: ctl=%h result=%h", i, b[15:0], ex_mem[111:80]);
        end
    endtask

    task automatic test_mult_mflo();
        logic [185:0] b;
        int stalls, bad;
        b = mk(5'd0, 5'd0, 32'd7, 32'd0, 32'hFFFF_FFFD, 16'h004C);
        step(b);
        model_md(4'd12, 32'hFFFF_FFFD, 32'd7);
        checks++; if (ex_mem !== '0 || md_busy !== MD)
            $display("FAIL mult_issue: got ex_mem=%h busy=%b expected 0 and %b", ex_mem, md_busy, MD);
        else passed++;
        @(posedge clk);
        #1 id_ex = mk(5'd0, 5'd3, 32'd0, 32'd0, 32'd0, 16'h0460);
        stalls = 0;
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (!stall_req) break;
            stalls++;
            @(negedge clk);
            #1 if (ex_mem !== '0) bad++;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        checks++; if (stalls !== (MD ? 32 : 0) || bad != 0)
            $display("FAIL mult_stall: got %0d stall cycles (%0d non-bubbles) expected %0d",
                     stalls, bad, MD ? 32 : 0); else passed++;
        checks++; if (lo !== (MD ? 32'hFFFF_FFEB : 32'd0) || hi !== (MD ? 32'hFFFF_FFFF : 32'd0))
            $display("FAIL mult_hilo: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo,
                     MD ? 32'hFFFF_FFFF : 32'd0, MD ? 32'hFFFF_FFEB : 32'd0); else passed++;
        checks++; if (ex_mem[116:112] !== 5'd3 || ex_mem[111:80] !== (MD ? 32'hFFFF_FFEB : 32'd0))
            $display("FAIL mflo_after_mult: got dest=%0d result=%h expected dest=3 result=%h",
                     ex_mem[116:112], ex_mem[111:80], MD ? 32'hFFFF_FFEB : 32'd0); else passed++;
        id_ex = '0;
        $display("mult_mflo: stalls=%0d hi=%h lo=%h", stalls, hi, lo);
    endtask

    task automatic test_muldiv_random();
        logic [3:0]  op;
        logic [31:0] a, bv;
        int cyc;
        for (int i = 0; i < 14; i++) begin
            if (i == 0) begin op = 4'd14; a = 32'hFFFF_FFF9; bv = 32'd2; end
            else if (i == 1) begin op = 4'd15; a = 32'd9; bv = 32'd0; end
            else if (i == 2) begin op = 4'd14; a = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
            else if (i == 3) begin op = 4'd14; a = 32'hFFFF_FFF0; bv = 32'd0; end
            else begin
                op = 4'($urandom_range(12, 15));
                a  = $urandom();
                bv = $urandom();
                if ($urandom_range(0, 4) == 0) bv = 32'd0;
                else if ($urandom_range(0, 3) == 0) bv = 32'($urandom_range(1, 9));
            end
            step(mk(5'd4, 5'd6, bv, $urandom(), a, {11'h002, 1'b0, op}));
            id_ex = '0;
            model_md(op, a, bv);
            checks++; if (ex_mem !== '0)
                $display("FAIL md_bubble_%0d: got %h expected 0", i, ex_mem); else passed++;
            wait_idle(cyc);
            checks++; if (cyc !== (MD ? 32 : 0))
                $display("FAIL md_latency_%0d: got %0d cycles expected %0d", i, cyc, MD ? 32 : 0);
            else passed++;
            checks++; if (hi !== m_hi || lo !== m_lo)
                $display("FAIL md_result_%0d: op=%0d a=%h b=%h got hi=%h lo=%h expected hi=%h lo=%h",
                         i, op, a, bv, hi, lo, m_hi, m_lo); else passed++;
            $display("muldiv %0d: op=%0d a=%h b=%h hi=%h lo=%h", i, op, a, bv, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        logic [185:0] b;
        logic [31:0]  a, bv;
        int cyc;
        a  = $urandom();
        bv = $urandom_range(1, 1000);
        step(mk(5'd0, 5'd0, bv, 32'd0, a, 16'h000F));
        model_md(4'd15, a, bv);
        for (int i = 0; i < 10; i++) begin
            b = rand_bundle(1'b0);
            @(posedge clk);
            #1 id_ex = b;
            #1;
            checks++; if (stall_req !== 1'b0)
                $display("FAIL b2b_stall_%0d: got %b expected 0", i, stall_req); else passed++;
            @(negedge clk);
            #1;
            checks++; if (ex_mem !== model_ex(b, m_hi, m_lo))
                $display("FAIL b2b_result_%0d: got %h expected %h", i, ex_mem, model_ex(b, m_hi, m_lo));
            else passed++;
            $display("b2b %0d: ctl=%h result=%h busy=%b", i, b[15:0], ex_mem[111:80], md_busy);
        end
        checks++; if (md_busy !== MD)
            $display("FAIL b2b_busy: got %b expected %b", md_busy, MD); else passed++;
        id_ex = '0;
        wait_idle(cyc);
        checks++; if (hi !== m_hi || lo !== m_lo)
            $display("FAIL b2b_divu: got hi=%h lo=%h expected hi=%h lo=%h", hi, lo, m_hi, m_lo);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        logic [185:0] b;
        step(mk(5'd0, 5'd0, 32'h9ABC_DEF0, 32'd0, 32'h1234_5678, 16'h004D));
        id_ex = '0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        m_hi = '0;
        m_lo = '0;
        #1;
        checks++; if (hi !== 32'd0 || lo !== 32'd0 || md_busy !== 1'b0)
            $display("FAIL midop_reset: got hi=%h lo=%h busy=%b expected 0 0 0", hi, lo, md_busy);
        else passed++;
        #1 rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        checks++; if (hi !== 32'd0 || lo !== 32'd0)
            $display("FAIL midop_no_partial: got hi=%h lo=%h expected 0", hi, lo); else passed++;
        b = mk(5'd0, 5'd7, 32'd0, 32'd0, 32'd0, 16'h0260);
        @(posedge clk);
        #1 id_ex = b;
        #1;
        checks++; if (stall_req !== 1'b0)
            $display("FAIL midop_mfhi_stall: got %b expected 0", stall_req); else passed++;
        @(negedge clk);
        #1;
        checks++; if (ex_mem !== model_ex(b, 32'd0, 32'd0) || ex_mem[111:80] !== 32'd0)
            $display("FAIL midop_mfhi: got %h expected %h", ex_mem, model_ex(b, 32'd0, 32'd0));
        else passed++;
        id_ex = '0;
        $display("reset_mid_op: hi=%h lo=%h", hi, lo);
    endtask

    initial begin
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_mult_mflo();
        test_muldiv_random();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
